// File: rtl/mem_access_ctrl.sv
// Sequences 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM
// as two half-word phases (low half first), stalling the pipeline via ready.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_w_en,
  input  logic               mem_r_en,
  input  logic [31:0]        alu_res,
  input  logic [31:0]        val_rm,
  output logic [31:0]        mem_out,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  input  logic [15:0]        sram_dq_in
);

  // state | meaning
  // IDLE  | waiting for a request; ready follows the request lines
  // LO    | low half-word on the bus for WAIT_CYCLES cycles
  // HI    | high half-word on the bus for WAIT_CYCLES cycles
  // DONE  | access complete, pipeline advances, requests ignored
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t               state, state_nx;
  logic [3:0]           cnt;
  logic                 op_wr;
  logic [SRAM_AW-2:0]   waddr_q;
  logic [31:0]          val_q;
  logic [15:0]          data_lo;
  logic [31:0]          waddr;
  logic                 req;
  logic                 phase_end;
  logic                 unused_bits;

  assign req         = mem_w_en | mem_r_en;
  assign waddr       = ({alu_res[31:2], 2'b00} - BASE_ADDR) >> 2;
  assign phase_end   = (cnt == CNT_LAST);
  assign unused_bits = ^{alu_res[1:0], waddr[31:SRAM_AW-1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state || state == IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr   <= 1'b0;
      waddr_q <= '0;
      val_q   <= '0;
      data_lo <= '0;
      mem_out <= '0;
    end else begin
      // write wins when both enables are high
      if (state == IDLE && req) begin
        op_wr   <= mem_w_en;
        waddr_q <= waddr[SRAM_AW-2:0];
        val_q   <= val_rm;
      end
      if (state == LO && phase_end && !op_wr)
        data_lo <= sram_dq_in;
      if (state == HI && phase_end && !op_wr)
        mem_out <= {sram_dq_in, data_lo};
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = LO;
      LO:      if (phase_end) state_nx = HI;
      HI:      if (phase_end) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state)
      IDLE: ready = ~req;
      LO: begin
        sram_addr = {waddr_q, 1'b0};
        if (op_wr) begin
          sram_dq_out = val_q[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
      end
      HI: begin
        sram_addr = {waddr_q, 1'b1};
        if (op_wr) begin
          sram_dq_out = val_q[31:16];
          sram_dq_oe  = 1'b1;
          // first HI cycle keeps we_n high so the two phases form separate pulses
          sram_we_n   = (WAIT_CYCLES > 1) && (cnt == 4'd0);
        end
      end
      DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule
